// File: rtl/la_readout.sv
// la_readout -- read-side engine for the logic-analyzer capture RAM.
//
// After an accepted start, walks the RAM read port from start_addr in
// increments of step (0 counts as 1, addresses wrap modulo DEPTH), and streams
// length samples (0 counts as DEPTH) out over a valid/ready byte interface.
//
// Optional build macro: LA_RD_HEADER_EN
//   When defined, four header bytes (0xA5, {7'b0,L[16]}, L[15:8], L[7:0], with
//   L = effective length truncated to 17 bits) precede the samples. RAM reads
//   keep prefetching into the skid buffer while the header is being sent.
//
// Ports:
//   clk_50M     system clock, shared with the RAM read clock
//   rst         synchronous active-high reset
//   start       one-cycle readout request (ignored while busy)
//   start_addr  first address; sampled on an accepted start
//   length      sample count, 0 = DEPTH; sampled on an accepted start
//   step        address increment, 0 = 1; sampled on an accepted start
//   abort       terminate the current readout (no effect in IDLE)
//   rd_addr     RAM read address
//   rd_data     RAM read data, valid one cycle after rd_addr
//   out_data    stream data
//   out_valid   stream valid
//   out_ready   stream ready from the sink
//   busy        high from the cycle after an accepted start until done
//   done        one-cycle pulse on completion or abort
//   dbg_state   current FSM state (IDLE=0, READ=1, DRAIN=2)
//
// Handshake: a transfer happens in every cycle where out_valid && out_ready.
// Once out_valid is high it stays high with out_data unchanged until that
// transfer happens; only abort or reset can withdraw it.

module la_readout #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 131072
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [3:0]        step,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [3:0]        step_q;
  logic [CW-1:0]     len_q, issued_q, emit_q;
  logic              inflight_q;
  logic [DATA_W-1:0] buf0_q, buf1_q;
  logic [1:0]        cnt_q;
  logic              done_q;

  logic              issue, load, finish, flush, push;
  logic [ADDR_W-1:0] issue_addr, next_addr;
  logic [CW-1:0]     next_addr_w;
  logic              hdr_active, xfer, buf_pop, last_pop;
  logic [DATA_W-1:0] hdr_byte;
  logic [2:0]        occ_after;

  // Next sequential address, wrapped modulo DEPTH (DEPTH need not be 2^ADDR_W).
  assign next_addr_w = {1'b0, rd_addr_q} + CW'(step_q);
  assign next_addr   = (next_addr_w >= DEPTH_C) ? ADDR_W'(next_addr_w - DEPTH_C)
                                                : ADDR_W'(next_addr_w);

  assign out_valid = hdr_active | (cnt_q != 2'd0);
  assign out_data  = hdr_active ? hdr_byte : buf0_q;
  assign xfer      = out_valid & out_ready;
  assign buf_pop   = xfer & ~hdr_active;
  assign last_pop  = buf_pop && ((emit_q + CW'(1)) == len_q);
  assign flush     = abort && (state_q != IDLE);
  assign push      = inflight_q & ~flush;

  // Occupancy counts the entry leaving this cycle as gone, so a steady
  // out_ready keeps one read in flight and one entry buffered: 1 sample/cycle.
  assign occ_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, buf_pop};

  // The issuing read address is driven combinationally so the first read goes
  // out in the start cycle itself; rd_addr_q holds it afterwards.
  assign rd_addr   = issue ? issue_addr : rd_addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_addr = next_addr;
    load       = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          issue      = 1'b1;
          issue_addr = start_addr;
          state_d    = READ;
        end
      end
      READ: begin
        if (abort || last_pop) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else if (issued_q == len_q) begin
          state_d = DRAIN;
        end else if (occ_after < 3'd2) begin
          issue = 1'b1;
        end
      end
      DRAIN: begin
        if (abort || last_pop) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      step_q     <= 4'd1;
      len_q      <= '0;
      issued_q   <= '0;
      emit_q     <= '0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= finish;
      inflight_q <= issue;
      if (issue) rd_addr_q <= issue_addr;
      if (load) begin
        step_q   <= (step == 4'd0) ? 4'd1 : step;
        len_q    <= (length == '0) ? DEPTH_C : {1'b0, length};
        issued_q <= CW'(1);
        emit_q   <= '0;
      end else begin
        if (issue)   issued_q <= issued_q + CW'(1);
        if (buf_pop) emit_q   <= emit_q + CW'(1);
      end
      // Two-entry skid buffer; buf0_q is the head presented on out_data.
      if (flush) begin
        cnt_q <= 2'd0;
      end else begin
        case ({push, buf_pop})
          2'b10: begin
            if (cnt_q == 2'd0) buf0_q <= rd_data;
            else               buf1_q <= rd_data;
            cnt_q <= cnt_q + 2'd1;
          end
          2'b01: begin
            buf0_q <= buf1_q;
            cnt_q  <= cnt_q - 2'd1;
          end
          2'b11: begin
            if (cnt_q == 2'd1) begin
              buf0_q <= rd_data;
            end else begin
              buf0_q <= buf1_q;
              buf1_q <= rd_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LA_RD_HEADER_EN
  // hdr_q counts header bytes still to send (4 down to 1); 0 = samples phase.
  logic [2:0]  hdr_q;
  logic [16:0] hdr_len;

  assign hdr_active = (hdr_q != 3'd0);
  assign hdr_len    = 17'(len_q);

  always_comb begin
    hdr_byte = '0;
    case (hdr_q)
      3'd4:    hdr_byte = DATA_W'(8'hA5);
      3'd3:    hdr_byte = DATA_W'({7'b0, hdr_len[16]});
      3'd2:    hdr_byte = DATA_W'(hdr_len[15:8]);
      3'd1:    hdr_byte = DATA_W'(hdr_len[7:0]);
      default: hdr_byte = '0;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst)                     hdr_q <= 3'd0;
    else if (load)               hdr_q <= 3'd4;
    else if (flush)              hdr_q <= 3'd0;
    else if (xfer && hdr_active) hdr_q <= hdr_q - 3'd1;
  end
`else
  assign hdr_active = 1'b0;
  assign hdr_byte   = '0;
`endif

endmodule

// File: tb/tb_la_readout.sv
// Testbench for la_readout: RAM model with 1-cycle read latency, directed and
// randomized readouts checked against expectations computed from address
// arithmetic ((start + k*step) mod DEPTH) and the RAM contents.

module tb_la_readout;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 131072;

  // ---------------- clock / reset ----------------
  logic clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] length;
  logic [3:0]        step;
  logic              abort;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  la_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .step       (step),
    .abort      (abort),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // RAM model: synchronous read, data valid one cycle after the address.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk_50M) rd_data <= ram[rd_addr];

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                exp_addr_q[$];
  int                got_addr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // rmode 0: always ready; 1: repeating 1,0,0,1,0,1; 2: random (~75% ready)
  function automatic logic ready_for(input int rmode, input int c);
    logic [5:0] pat;
    pat = 6'b101001;
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return pat[c % 6];
    return ($urandom_range(0, 3) != 0);
  endfunction

  // ---------------- driver: one complete readout ----------------
  task automatic run_readout(input int sa, input int len, input int st, input int rmode,
                             input int abort_after, input int dup_cycle,
                             input bit chk_lat, input bit chk_addr);
    int st_eff, len_eff, n_exp, c, budget, done_due, xfers, first_v, abort_cyc, a, l17;
    logic pv, pr;
    logic [DATA_W-1:0] pd;
    logic [ADDR_W-1:0] last_a;
    st_eff  = (st == 0) ? 1 : st;
    len_eff = (len == 0) ? DEPTH : len;
    exp_q.delete();
    exp_addr_q.delete();
    got_addr_q.delete();
    l17 = len_eff & 32'h1FFFF;
`ifdef LA_RD_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(l17 >> 16));
    exp_q.push_back(8'((l17 >> 8) & 255));
    exp_q.push_back(8'(l17 & 255));
`endif
    for (int k = 0; k < len_eff; k++) begin
      a = (sa + k * st_eff) % DEPTH;
      exp_addr_q.push_back(a);
      exp_q.push_back(ram[a]);
    end
    n_exp  = exp_q.size();
    budget = len_eff * 4 + 100;

    // cycle 0: start request
    @(negedge clk_50M);
    start      = 1'b1;
    start_addr = ADDR_W'(sa);
    length     = ADDR_W'(len);
    step       = 4'(st);
    abort      = 1'b0;
    out_ready  = ready_for(rmode, 0);
    #1;
    check("start_rd_addr", rd_addr, sa);
    check("start_busy", busy, 0);
    check("start_valid", out_valid, 0);
    got_addr_q.push_back(int'(rd_addr));
    last_a    = rd_addr;
    pv        = 1'b0;
    pr        = 1'b0;
    pd        = '0;
    done_due  = -1;
    xfers     = 0;
    first_v   = -1;
    abort_cyc = -1;

    for (c = 1; c < budget; c++) begin
      @(negedge clk_50M);
      // inputs other than start must be ignored once the start is accepted
      start      = (c == dup_cycle);
      start_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      length     = ADDR_W'($urandom_range(1, 200));
      step       = 4'($urandom_range(0, 15));
      abort      = (abort_after > 0 && abort_cyc < 0 && xfers == abort_after);
      if (abort) abort_cyc = c;
      out_ready  = abort ? 1'b0 : ready_for(rmode, c);
      #1;
      check("done", done, (c == done_due));
      check("busy", busy, (c != done_due));
      if (pv && !pr && (c != abort_cyc + 1)) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
      end
      if (abort_cyc >= 0 && c == abort_cyc + 1) check("abort_valid", out_valid, 0);
      if (out_valid && first_v < 0) first_v = c;
      if (rd_addr != last_a) begin
        got_addr_q.push_back(int'(rd_addr));
        last_a = rd_addr;
      end
      if (out_valid && out_ready) begin
        xfers++;
        if (rmode == 0 && abort_after == 0) check("back_to_back", c, first_v + xfers - 1);
        if (exp_q.size() == 0) check("extra_xfer", xfers, n_exp);
        else check("data", out_data, exp_q.pop_front());
        if (xfers == n_exp) done_due = c + 1;
      end
      if (abort_cyc == c) done_due = c + 1;
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      if (c == done_due) break;
    end
    if (c >= budget) check("timeout_done", done, 1);

    start = 1'b0;
    abort = 1'b0;
    @(negedge clk_50M);
    #1;
    check("done_once", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    check("xfer_count", xfers, (abort_after > 0) ? abort_after : n_exp);
`ifndef LA_RD_HEADER_EN
    if (chk_lat) check("first_valid_latency", first_v, 2);
`endif
    if (chk_addr) begin
      check("addr_count", got_addr_q.size(), len_eff);
      for (int k = 0; k < got_addr_q.size() && k < len_eff; k++)
        check("rd_addr_seq", got_addr_q[k], exp_addr_q[k]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    step       = '0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i);

    repeat (3) @(negedge clk_50M);
    rst = 1'b0;
    #1;
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // RAM[i]=i: samples 10..13 back to back, latency 2
    run_readout(10, 4, 0, 0, 0, -1, 1'b1, 1'b1);
    // address wrap at the top of the RAM
    run_readout(131070, 4, 1, 0, 0, -1, 1'b1, 1'b1);
    // backpressure pattern
    run_readout(int'($urandom_range(0, DEPTH - 1)), 6, 1, 1, 0, -1, 1'b0, 1'b1);
    // step 3 plus an ignored second start while busy
    run_readout(0, 3, 3, 0, 0, 2, 1'b1, 1'b1);

    for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'($urandom);

    // abort after the 5th transfer, then a fresh start works
    run_readout(int'($urandom_range(0, DEPTH - 1)), 100, 5, 0, 5, -1, 1'b0, 1'b0);
    run_readout(int'($urandom_range(0, DEPTH - 1)), 10, 2, 2, 0, -1, 1'b0, 1'b1);

    // reset in the middle of a readout
    @(negedge clk_50M);
    start      = 1'b1;
    start_addr = ADDR_W'(500);
    length     = ADDR_W'(100);
    step       = 4'd2;
    out_ready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_50M);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk_50M);
    rst = 1'b0;
    #1;
    check("midrst_rd_addr", rd_addr, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50M);
      #1;
      check("midrst_no_done", done, 0);
      check("midrst_no_valid", out_valid, 0);
    end

    // randomized readouts
    for (int r = 0; r < 6; r++)
      run_readout(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 30)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 0, -1, 1'b0, 1'b1);

`ifdef LA_RD_HEADER_EN
    run_readout(0, 32'h10203, 1, 0, 0, -1, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
